// File: rtl/uart_rx.sv
// uart_rx: UART receiver with mid-bit sampling, LSB-first assembly and a one-word ready/valid buffer.
// Optional feature macro: UART_RX_PARITY_EN adds an even-parity bit and the parity_error output.
module uart_rx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int DATA_BITS    = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 rx_in,
  input  logic                 rx_ready,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 framing_error,
  output logic                 overrun,
`ifdef UART_RX_PARITY_EN
  output logic                 parity_error,
`endif
  output logic                 busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [CNT_W-1:0] CNT_BIT  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE = 3'd0, START = 3'd1, DATA = 3'd2, PARITY = 3'd3, STOP = 3'd4} state_t;

  function automatic logic even_parity_ok(input logic [DATA_BITS-1:0] word, input logic par);
    return ((^word) ^ par) == 1'b0;
  endfunction

  logic parity_bit;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, START = 2'd1, DATA = 2'd2, STOP = 2'd3} state_t;
`endif

  state_t               state;
  state_t               state_next;
  logic [CNT_W-1:0]     clk_cnt;
  logic [IDX_W-1:0]     bit_idx;
  logic [DATA_BITS-1:0] shift;
  logic                 half_tick;
  logic                 bit_tick;
  logic                 stop_sample;
  logic                 frame_ok;
  logic                 load;

  // Next-state decode plus the sample strobes that drive the output buffer
  always_comb begin
    state_next  = state;
    half_tick   = (clk_cnt == CNT_HALF);
    bit_tick    = (clk_cnt == CNT_BIT);
    stop_sample = (state == STOP) && bit_tick;
`ifdef UART_RX_PARITY_EN
    frame_ok    = stop_sample && rx_in && even_parity_ok(shift, parity_bit);
`else
    frame_ok    = stop_sample && rx_in;
`endif
    load        = frame_ok && (!rx_valid || rx_ready);
    case (state)
      IDLE:    if (!rx_in) state_next = START; else state_next = IDLE;
      START: begin
        if (half_tick) begin
          if (rx_in) state_next = IDLE; else state_next = DATA;
        end else begin
          state_next = START;
        end
      end
`ifdef UART_RX_PARITY_EN
      DATA:    if (bit_tick && bit_idx == IDX_LAST) state_next = PARITY; else state_next = DATA;
      PARITY:  if (bit_tick) state_next = STOP; else state_next = PARITY;
`else
      DATA:    if (bit_tick && bit_idx == IDX_LAST) state_next = STOP; else state_next = DATA;
`endif
      // Leave STOP right at the mid-stop sample so a following start bit is seen.
      STOP:    if (bit_tick) state_next = IDLE; else state_next = STOP;
      default: state_next = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Bit timing counters and right-shifting deserialiser
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      clk_cnt <= {CNT_W{1'b0}};
      bit_idx <= {IDX_W{1'b0}};
      shift   <= {DATA_BITS{1'b0}};
`ifdef UART_RX_PARITY_EN
      parity_bit <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          clk_cnt <= {CNT_W{1'b0}};
          bit_idx <= {IDX_W{1'b0}};
        end
        START: begin
          if (half_tick) clk_cnt <= {CNT_W{1'b0}};
          else           clk_cnt <= clk_cnt + CNT_W'(1);
        end
        DATA: begin
          if (bit_tick) begin
            clk_cnt <= {CNT_W{1'b0}};
            shift   <= {rx_in, shift[DATA_BITS-1:1]};
            bit_idx <= bit_idx + IDX_W'(1);
          end else begin
            clk_cnt <= clk_cnt + CNT_W'(1);
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (bit_tick) begin
            clk_cnt    <= {CNT_W{1'b0}};
            parity_bit <= rx_in;
          end else begin
            clk_cnt <= clk_cnt + CNT_W'(1);
          end
        end
`endif
        STOP: begin
          if (bit_tick) clk_cnt <= {CNT_W{1'b0}};
          else          clk_cnt <= clk_cnt + CNT_W'(1);
        end
        default: begin
          clk_cnt <= {CNT_W{1'b0}};
          bit_idx <= {IDX_W{1'b0}};
        end
      endcase
    end
  end

  // Output buffer, status pulses and busy flag
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rx_data       <= {DATA_BITS{1'b0}};
      rx_valid      <= 1'b0;
      framing_error <= 1'b0;
      overrun       <= 1'b0;
      busy          <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_error  <= 1'b0;
`endif
    end else begin
      busy          <= (state_next != IDLE);
      framing_error <= stop_sample && !rx_in;
      overrun       <= frame_ok && rx_valid && !rx_ready;
`ifdef UART_RX_PARITY_EN
      parity_error  <= stop_sample && rx_in && !even_parity_ok(shift, parity_bit);
`endif
      if (load) begin
        rx_data  <= shift;
        rx_valid <= 1'b1;
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end else begin
        rx_valid <= rx_valid;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed frames against a frame-level model of the receiver's buffer and pulses.
// Build with UART_RX_PARITY_EN defined to also exercise the parity feature.
module tb_uart_rx;

  localparam int CPB = 4;
  localparam int DB  = 8;
`ifdef UART_RX_PARITY_EN
  localparam int PB  = 1;
`else
  localparam int PB  = 0;
`endif
  localparam int K_WORD = 0;
  localparam int K_FE   = 1;
  localparam int K_PE   = 2;

  logic          clock = 1'b0;
  logic          reset;
  logic          rx_in;
  logic          rx_ready;
  logic [DB-1:0] rx_data;
  logic          rx_valid;
  logic          framing_error;
  logic          overrun;
  logic          busy;
`ifdef UART_RX_PARITY_EN
  logic          parity_error;
`endif

  uart_rx #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB)) dut (
    .clock         (clock),
    .reset         (reset),
    .rx_in         (rx_in),
    .rx_ready      (rx_ready),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .framing_error (framing_error),
    .overrun       (overrun),
`ifdef UART_RX_PARITY_EN
    .parity_error  (parity_error),
`endif
    .busy          (busy)
  );

  always #5 clock = ~clock;

  // Frame-level model: each sent frame is one scheduled event at its mid-stop-bit edge.
  typedef struct packed {
    int            ptr;
    logic          valid;
    logic [DB-1:0] data;
    logic          fe;
    logic          ov;
    logic          pe;
  } model_t;

  model_t        m;
  int            cyc = 0;
  int            ev_cyc  [0:63];
  int            ev_kind [0:63];
  logic [DB-1:0] ev_word [0:63];
  int            n_ev = 0;

  int passed = 0;
  int total  = 0;
  int n_vcyc = 0;
  int n_fe   = 0;
  int n_ov   = 0;
  int n_pe   = 0;
  logic [DB-1:0] last_data = 8'h00;

  function automatic model_t model_step(input model_t cur, input int now, input logic rdy, input logic rst);
    model_t nx;
    logic   took;
    nx    = cur;
    nx.fe = 1'b0;
    nx.ov = 1'b0;
    nx.pe = 1'b0;
    took  = 1'b0;
    if (rst) begin
      nx.valid = 1'b0;
      nx.data  = 8'h00;
      nx.ptr   = n_ev;
    end else begin
      if (cur.ptr < n_ev && ev_cyc[cur.ptr] == now) begin
        if (ev_kind[cur.ptr] == K_WORD) begin
          if (!cur.valid || rdy) begin
            nx.data  = ev_word[cur.ptr];
            nx.valid = 1'b1;
            took     = 1'b1;
          end else begin
            nx.ov = 1'b1;
          end
        end else if (ev_kind[cur.ptr] == K_FE) begin
          nx.fe = 1'b1;
        end else begin
          nx.pe = 1'b1;
        end
        nx.ptr = cur.ptr + 1;
      end
      if (!took && cur.valid && rdy) nx.valid = 1'b0;
    end
    return nx;
  endfunction

  always @(posedge clock) cyc <= cyc + 1;
  always @(posedge clock) m <= model_step(m, cyc + 1, rx_ready, reset);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total = total + 1;
    if (act === exp) passed = passed + 1;
    else $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
  endtask

  task automatic compare_loop();
    forever begin
      @(negedge clock);
      if (!reset) begin
        check("rx_valid", {31'd0, rx_valid}, {31'd0, m.valid});
        if (m.valid) check("rx_data", {24'd0, rx_data}, {24'd0, m.data});
        check("framing_error", {31'd0, framing_error}, {31'd0, m.fe});
        check("overrun", {31'd0, overrun}, {31'd0, m.ov});
`ifdef UART_RX_PARITY_EN
        check("parity_error", {31'd0, parity_error}, {31'd0, m.pe});
        if (parity_error) n_pe = n_pe + 1;
`endif
        if (rx_valid) begin
          n_vcyc    = n_vcyc + 1;
          last_data = rx_data;
        end
        if (framing_error) n_fe = n_fe + 1;
        if (overrun) n_ov = n_ov + 1;
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic drive_bit(input logic b);
    rx_in = b;
    repeat (CPB) @(negedge clock);
  endtask

  // Called on a falling edge; the start bit is seen at the next rising edge.
  task automatic send_frame(input logic [DB-1:0] d, input logic stop_b, input logic par_b);
    int s;
    int k;
    s = cyc + 1;
    if (!stop_b) k = K_FE;
    else if (PB == 1 && (((^d) ^ par_b) == 1'b1)) k = K_PE;
    else k = K_WORD;
    ev_cyc[n_ev]  = s + CPB / 2 + CPB * (DB + PB + 1);
    ev_kind[n_ev] = k;
    ev_word[n_ev] = d;
    n_ev = n_ev + 1;
    drive_bit(1'b0);
    for (int i = 0; i < DB; i++) drive_bit(d[i]);
    if (PB == 1) drive_bit(par_b);
    drive_bit(stop_b);
    rx_in = 1'b1;
  endtask

  task automatic stimulus();
    int bv;
    int bfe;
    int bov;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("reset_rx_valid", {31'd0, rx_valid}, 32'd0);
    check("reset_rx_data", {24'd0, rx_data}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_flags", {30'd0, framing_error, overrun}, 32'd0);

    // 0xA5 with the consumer always ready: a single valid cycle
    rx_ready = 1'b1;
    bv = n_vcyc; bfe = n_fe; bov = n_ov;
    send_frame(8'hA5, 1'b1, ^8'hA5);
    idle(6);
    check("a5_valid_cycles", n_vcyc - bv, 32'd1);
    check("a5_data", {24'd0, last_data}, 32'h000000A5);
    check("a5_no_flags", (n_fe - bfe) + (n_ov - bov), 32'd0);

    // Back-to-back words with no consumer: the second is an overrun
    rx_ready = 1'b0;
    bov = n_ov;
    send_frame(8'h3C, 1'b1, ^8'h3C);
    send_frame(8'hC3, 1'b1, ^8'hC3);
    idle(6);
    check("ovr_count", n_ov - bov, 32'd1);
    check("ovr_held_valid", {31'd0, rx_valid}, 32'd1);
    check("ovr_held_data", {24'd0, rx_data}, 32'h0000003C);
    rx_ready = 1'b1;
    @(negedge clock);
    rx_ready = 1'b0;
    idle(2);
    check("drained", {31'd0, rx_valid}, 32'd0);

    // 0x55 with a low stop bit
    bv = n_vcyc; bfe = n_fe;
    send_frame(8'h55, 1'b0, ^8'h55);
    idle(8);
    check("fe_count", n_fe - bfe, 32'd1);
    check("fe_no_valid", n_vcyc - bv, 32'd0);
    check("fe_idle", {31'd0, busy}, 32'd0);

    // One-clock glitch is a false start
    bv = n_vcyc; bfe = n_fe; bov = n_ov;
    rx_in = 1'b0;
    @(negedge clock);
    check("glitch_busy", {31'd0, busy}, 32'd1);
    rx_in = 1'b1;
    repeat (2) @(negedge clock);
    check("glitch_released", {31'd0, busy}, 32'd0);
    idle(6);
    check("glitch_quiet", (n_vcyc - bv) + (n_fe - bfe) + (n_ov - bov), 32'd0);

    // Reset inside the 4th data bit of 0xFF with a word already buffered
    send_frame(8'h99, 1'b1, ^8'h99);
    idle(2);
    check("pre_reset_buffered", {31'd0, rx_valid}, 32'd1);
    drive_bit(1'b0);
    for (int i = 0; i < 3; i++) drive_bit(1'b1);
    repeat (2) @(negedge clock);
    check("mid_frame_busy", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("post_reset_valid", {31'd0, rx_valid}, 32'd0);
    check("post_reset_busy", {31'd0, busy}, 32'd0);
    send_frame(8'h12, 1'b1, ^8'h12);
    idle(4);
    check("after_reset_valid", {31'd0, rx_valid}, 32'd1);
    check("after_reset_data", {24'd0, rx_data}, 32'h00000012);

`ifdef UART_RX_PARITY_EN
    begin
      int bpe;
      rx_ready = 1'b1;
      idle(2);
      bv = n_vcyc; bpe = n_pe;
      send_frame(8'h07, 1'b1, 1'b1);
      idle(6);
      check("par_ok_valid", n_vcyc - bv, 32'd1);
      check("par_ok_data", {24'd0, last_data}, 32'h00000007);
      check("par_ok_no_pe", n_pe - bpe, 32'd0);
      bv = n_vcyc; bpe = n_pe;
      send_frame(8'h07, 1'b1, 1'b0);
      idle(6);
      check("par_bad_pe", n_pe - bpe, 32'd1);
      check("par_bad_no_valid", n_vcyc - bv, 32'd0);
      bpe = n_pe; bfe = n_fe;
      send_frame(8'h07, 1'b0, 1'b0);
      idle(8);
      check("both_bad_fe", n_fe - bfe, 32'd1);
      check("both_bad_no_pe", n_pe - bpe, 32'd0);
    end
`endif
    idle(4);
  endtask

  initial begin
    reset    = 1'b1;
    rx_in    = 1'b1;
    rx_ready = 1'b0;
    fork
      compare_loop();
      stimulus();
    join_any
    disable fork;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
